// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven HH:MM set sequencer that edits a BCD shadow and strobes a load into clock2.
// The shadow register doubles as switch_o, so an aborted edit leaves the last edited value on the bus.
module clock_set_ctrl #(
   parameter int HRS_MIN_P     = 1,
   parameter int HRS_MAX_P     = 12,
   parameter int LOAD_CYCLES_P = 2,
   parameter int BLINK_DIV_P   = 2,
   parameter int TIMEOUT_P     = 120
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        setMode_i,
   input  logic        next_i,
   input  logic        up_i,
   input  logic        down_i,
   input  logic [15:0] time_bcd_i,
   output logic        nLoadNow_o,
   output logic [15:0] switch_o,
   output logic        setActive_o,
   output logic        blankHrs_o,
   output logic        blankMins_o
);
   localparam int LW = $clog2(LOAD_CYCLES_P + 1);
   localparam int BW = $clog2(BLINK_DIV_P + 1);
   localparam int TW = $clog2(TIMEOUT_P + 2);
   localparam logic [7:0] hMinBcd = 8'(((HRS_MIN_P / 10) * 16) + (HRS_MIN_P % 10));
   localparam logic [7:0] hMaxBcd = 8'(((HRS_MAX_P / 10) * 16) + (HRS_MAX_P % 10));

   typedef enum logic [1:0] {IDLE, SET_HRS, SET_MINS, COMMIT} state_t;

   state_t        state, nextState;
   logic [15:0]   shadow, nextShadow, captured;
   logic [3:0]    prevBtn, btn, edges;
   logic [LW-1:0] loadCnt;
   logic [BW-1:0] blinkCnt;
   logic [TW-1:0] toCnt;
   logic          nLoad, phase;
   logic          setEdge, nextEdge, adjUp, adjDown, anyEdge, inSet, timedOut, blinkTick;
   logic [7:0]    hrVal, field, fieldInc, fieldDec;
   logic          hrOk, minOk;

   // Wrapping BCD step with per-digit carry/borrow; the operand is always a legal value.
   function automatic logic [7:0] bcdInc(input logic [7:0] v, input logic [7:0] hi, input logic [7:0] lo);
      return (v == hi) ? lo : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcdDec(input logic [7:0] v, input logic [7:0] hi, input logic [7:0] lo);
      return (v == lo) ? hi : (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
   endfunction

   assign btn      = {setMode_i, next_i, up_i, down_i};
   assign edges    = btn & ~prevBtn;
   assign setEdge  = edges[3];
   assign nextEdge = edges[2];
   assign adjUp    = edges[1] & ~edges[0];
   assign adjDown  = edges[0] & ~edges[1];
   assign anyEdge  = |edges;
   assign inSet    = (state == SET_HRS) || (state == SET_MINS);
   assign timedOut = (TIMEOUT_P != 0) && inSet && !anyEdge && (toCnt == TW'(TIMEOUT_P - 1));

   assign hrVal    = {4'd0, time_bcd_i[15:12]} * 8'd10 + {4'd0, time_bcd_i[11:8]};
   assign hrOk     = (time_bcd_i[15:12] <= 4'd9) && (time_bcd_i[11:8] <= 4'd9) &&
                     (hrVal >= 8'(HRS_MIN_P)) && (hrVal <= 8'(HRS_MAX_P));
   assign minOk    = (time_bcd_i[7:4] <= 4'd5) && (time_bcd_i[3:0] <= 4'd9);
   assign captured = {hrOk ? time_bcd_i[15:8] : hMinBcd, minOk ? time_bcd_i[7:0] : 8'h00};

   assign field    = (state == SET_HRS) ? shadow[15:8] : shadow[7:0];
   assign fieldInc = (state == SET_HRS) ? bcdInc(field, hMaxBcd, hMinBcd) : bcdInc(field, 8'h59, 8'h00);
   assign fieldDec = (state == SET_HRS) ? bcdDec(field, hMaxBcd, hMinBcd) : bcdDec(field, 8'h59, 8'h00);

   always_comb begin
      nextState  = state;
      nextShadow = shadow;
      case (state)
         IDLE: begin
            nextState  = setEdge ? SET_HRS : IDLE;
            nextShadow = setEdge ? captured : shadow;
         end
         SET_HRS, SET_MINS: begin
            if (setEdge || timedOut) nextState = IDLE;
            else if (nextEdge) nextState = (state == SET_HRS) ? SET_MINS : COMMIT;
            else if (adjUp || adjDown) begin
               if (state == SET_HRS) nextShadow[15:8] = adjUp ? fieldInc : fieldDec;
               else nextShadow[7:0] = adjUp ? fieldInc : fieldDec;
            end
         end
         default: nextState = (loadCnt == LW'(LOAD_CYCLES_P)) ? IDLE : COMMIT;
      endcase
   end

   assign blinkTick = (state != IDLE) && (blinkCnt == BW'(BLINK_DIV_P - 1));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state    <= IDLE;
         shadow   <= '0;
         prevBtn  <= '0;
         nLoad    <= 1'b1;
         loadCnt  <= '0;
         blinkCnt <= '0;
         phase    <= 1'b0;
         toCnt    <= '0;
      end else begin
         state    <= nextState;
         shadow   <= nextShadow;
         prevBtn  <= btn;
         nLoad    <= !((state == COMMIT) && (nextState == COMMIT));
         loadCnt  <= (state == COMMIT) ? loadCnt + 1'b1 : '0;
         blinkCnt <= (nextState == IDLE || blinkTick) ? '0 : (state != IDLE) ? blinkCnt + 1'b1 : blinkCnt;
         phase    <= (nextState == IDLE) ? 1'b0 : phase ^ blinkTick;
         toCnt    <= (anyEdge || nextState != state || !inSet) ? '0 : toCnt + 1'b1;
      end
   end

   assign nLoadNow_o  = nLoad;
   assign switch_o    = shadow;
   assign setActive_o = state != IDLE;
   assign blankHrs_o  = phase && (state == SET_HRS);
   assign blankMins_o = phase && (state == SET_MINS);
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: randomized and directed checks of clock_set_ctrl against an arithmetic reference model.
module tb_clock_set_ctrl;
   localparam int HMIN = 1, HMAX = 12, LOADC = 2, BDIV = 2, TOUT = 120;

   logic        clk = 0, reset = 1, setMode = 0, nxt = 0, up = 0, down = 0;
   logic [15:0] timeBcd = 16'h0000;
   logic        nLoad, act, blankH, blankM;
   logic [15:0] sw;

   clock_set_ctrl #(.HRS_MIN_P(HMIN), .HRS_MAX_P(HMAX), .LOAD_CYCLES_P(LOADC),
                    .BLINK_DIV_P(BDIV), .TIMEOUT_P(TOUT)) dut (
      .clk_i(clk), .reset_i(reset), .setMode_i(setMode), .next_i(nxt), .up_i(up), .down_i(down),
      .time_bcd_i(timeBcd), .nLoadNow_o(nLoad), .switch_o(sw), .setActive_o(act),
      .blankHrs_o(blankH), .blankMins_o(blankM));

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   // model: mode 0 idle, 1 hours, 2 minutes, 3 commit; hours/minutes kept as plain integers
   int mMode = 0, mH = 0, mM = 0, mQuiet = 0, mAct = 0, mK = 0;
   logic [15:0] mSw = 16'h0000;
   logic mNLoad = 1'b1, pS = 0, pN = 0, pU = 0, pD = 0;

   function automatic logic [7:0] toBcd(input int v);
      return 8'((v / 10) * 16 + v % 10);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic modelEdge();
      logic eS, eN, eU, eD, any;
      int old, ht, hu, mt, mu;
      if (reset) begin
         mMode = 0; mSw = 16'h0000; mNLoad = 1'b1; mAct = 0; mQuiet = 0; mK = 0;
         pS = 0; pN = 0; pU = 0; pD = 0;
         return;
      end
      eS = setMode && !pS; eN = nxt && !pN; eU = up && !pU; eD = down && !pD;
      pS = setMode; pN = nxt; pU = up; pD = down;
      any = eS || eN || eU || eD;
      old = mMode;
      case (old)
         0: if (eS) begin
            ht = int'(timeBcd[15:12]); hu = int'(timeBcd[11:8]);
            mt = int'(timeBcd[7:4]);   mu = int'(timeBcd[3:0]);
            mH = (ht <= 9 && hu <= 9 && ht * 10 + hu >= HMIN && ht * 10 + hu <= HMAX) ? ht * 10 + hu : HMIN;
            mM = (mt <= 5 && mu <= 9) ? mt * 10 + mu : 0;
            mMode = 1;
         end
         1, 2: begin
            if (eS) mMode = 0;
            else if (eN) begin mMode = old + 1; mK = 0; end
            else if (eU != eD) begin
               if (old == 1) mH = eU ? (mH == HMAX ? HMIN : mH + 1) : (mH == HMIN ? HMAX : mH - 1);
               else mM = eU ? (mM + 1) % 60 : (mM + 59) % 60;
            end
            if (mMode == old) begin
               mQuiet = any ? 0 : mQuiet + 1;
               if (TOUT != 0 && mQuiet == TOUT) mMode = 0;
            end
         end
         default: begin
            mK++;
            mNLoad = (mK <= LOADC) ? 1'b0 : 1'b1;
            if (mK > LOADC) mMode = 0;
         end
      endcase
      if (mMode != old) mQuiet = 0;
      mAct = (old != 0 && mMode != 0) ? mAct + 1 : 0;
      if (mMode != 0) mSw = {toBcd(mH), toBcd(mM)};
   endtask

   task automatic step();
      logic ph;
      @(posedge clk);
      modelEdge();
      #1;
      ph = ((mAct / BDIV) % 2) == 1;
      check("cycle", {12'd0, nLoad, act, blankH, blankM, sw},
            {12'd0, mNLoad, 1'(mMode != 0), 1'(ph && mMode == 1), 1'(ph && mMode == 2), mSw});
   endtask

   // 0 setMode, 1 next, 2 up, 3 down: one cycle high then one cycle low
   task automatic press(input int which);
      setMode = (which == 0); nxt = (which == 1); up = (which == 2); down = (which == 3);
      step();
      setMode = 0; nxt = 0; up = 0; down = 0;
      step();
   endtask

   task automatic doReset();
      reset = 1; setMode = 0; nxt = 0; up = 0; down = 0;
      step();
      reset = 0;
      step();
   endtask

   int lows;

   initial begin
      // reset then quiet idle
      doReset();
      check("reset_state", {13'd0, nLoad, act, sw}, {13'd0, 1'b1, 1'b0, 16'h0000});
      for (int i = 0; i < 20; i++) step();
      check("idle_hold", {13'd0, nLoad, act, sw}, {13'd0, 1'b1, 1'b0, 16'h0000});

      // full edit and commit from 12:59
      timeBcd = 16'h1259;
      press(0);
      check("capture_1259", {16'd0, sw}, 32'h1259);
      press(2);
      check("hrs_wrap_up", {16'd0, sw}, 32'h0159);
      press(1);
      press(2);
      check("min_wrap_up", {16'd0, sw}, 32'h0100);
      nxt = 1; step(); nxt = 0;
      check("commit_entry_nload", {31'd0, nLoad}, 32'd1);
      lows = 0;
      for (int i = 0; i < 8; i++) begin step(); lows += (nLoad == 1'b0) ? 1 : 0; end
      check("load_low_cycles", lows, 2);
      check("after_commit", {13'd0, nLoad, act, sw}, {13'd0, 1'b1, 1'b0, 16'h0100});

      // hour and minute wrap downward, minute wrap up keeps hours
      timeBcd = 16'h0100;
      press(0); press(3);
      check("hrs_wrap_down", {16'd0, sw}, 32'h1200);
      press(1); press(3);
      check("min_wrap_down", {16'd0, sw}, 32'h1259);
      press(2);
      check("min_59_up", {16'd0, sw}, 32'h1200);
      press(0);
      check("abort_idle", {30'd0, nLoad, act}, {30'd0, 1'b1, 1'b0});

      // invalid captures clamp
      timeBcd = 16'h2599; press(0);
      check("clamp_invalid", {16'd0, sw}, 32'h0100);
      press(0);
      timeBcd = 16'h0000; press(0);
      check("clamp_hour0", {16'd0, sw}, 32'h0100);
      press(0);

      // abort from minutes keeps last shadow on the bus
      timeBcd = 16'h1030;
      press(0); press(1); press(2);
      press(0);
      check("abort_mins", {13'd0, nLoad, act, sw}, {13'd0, 1'b1, 1'b0, 16'h1031});

      // timeout after 120 quiet cycles
      timeBcd = 16'h0745;
      press(0);
      for (int i = 0; i < 118; i++) step();
      check("timeout_not_yet", {31'd0, act}, 32'd1);
      step();
      check("timeout_fired", {13'd0, nLoad, act, sw}, {13'd0, 1'b1, 1'b0, 16'h0745});

      // held up counts once; simultaneous up/down ignored
      timeBcd = 16'h0330;
      press(0);
      up = 1;
      for (int i = 0; i < 5; i++) step();
      up = 0; step();
      check("held_up_once", {16'd0, sw}, 32'h0430);
      up = 1; down = 1; step();
      up = 0; down = 0; step();
      check("up_down_same", {16'd0, sw}, 32'h0430);
      press(0);

      // reset while the load strobe is low
      timeBcd = 16'h0930;
      press(0); press(1);
      nxt = 1; step(); nxt = 0; step();
      check("commit_low", {31'd0, nLoad}, 32'd0);
      reset = 1; step();
      check("reset_in_commit", {13'd0, nLoad, act, sw}, {13'd0, 1'b1, 1'b0, 16'h0000});
      reset = 0; step();

      // randomized soak
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 11) == 0) setMode = ~setMode;
         if ($urandom_range(0, 4) == 0) nxt = ~nxt;
         if ($urandom_range(0, 2) == 0) up = ~up;
         if ($urandom_range(0, 2) == 0) down = ~down;
         if ($urandom_range(0, 19) == 0) timeBcd = 16'($urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
